eth_rx_frame_buf: RTL

- Frame buffer directly downstream of the GMII receive MAC.
- Accepts 36-bit write words (32 data bits, bit 32 = last-word flag) plus commit (chk) and discard (clr) strobes.
- Stores frames in a single block RAM and makes a frame visible to the read side only after it is committed with a good FCS.
- Read side presents committed frames word by word with a valid/ready handshake. The consumer is the packet parser.

---
 rtl/eth_rx_frame_buf_if.sv | 24 ++
 rtl/eth_rx_frame_buf.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_buf_if.sv
// Write/read port bundle of the receive frame buffer.
// master = MAC writer + packet parser side, slave = the buffer.
interface eth_rx_frame_buf_if;
  logic        wr_en_in;
  logic [35:0] wr_d_in;
  logic        wr_chk_in;
  logic        wr_clr_in;
  logic        wr_full_out;
  logic        rd_valid_out;
  logic        rd_ready_in;
  logic [31:0] rd_d_out;
  logic        rd_last_out;
  logic        frame_avail_out;

  modport master (
    output wr_en_in, wr_d_in, wr_chk_in, wr_clr_in, rd_ready_in,
    input  wr_full_out, rd_valid_out, rd_d_out, rd_last_out, frame_avail_out
  );

  modport slave (
    input  wr_en_in, wr_d_in, wr_chk_in, wr_clr_in, rd_ready_in,
    output wr_full_out, rd_valid_out, rd_d_out, rd_last_out, frame_avail_out
  );
endinterface

// File: rtl/eth_rx_frame_buf.sv
// Receive frame buffer behind the GMII MAC: frames become readable only once committed.
// Define ETH_RX_FRAME_BUF_STATS_EN to add good/dropped frame counters.
module eth_rx_frame_buf #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned FULL_MARGIN = 4
) (
  input  logic               clk,
  input  logic               rst,
  eth_rx_frame_buf_if.slave  io
`ifdef ETH_RX_FRAME_BUF_STATS_EN
  ,
  output logic [15:0]        frames_ok_out,
  output logic [15:0]        frames_drop_out
`endif
);

  localparam int unsigned PW      = ADDR_W + 1;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned FULL_TH = DEPTH - FULL_MARGIN;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_HOLD} rd_state_e;

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        commit_ptr_q, commit_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        used, used_d;
  logic        ovf_q, ovf_d;
  logic        full_q, full_d;
  logic        avail_q, avail_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_d_q;
  logic        rd_last_q;
  rd_state_e   state_q, state_d;
  logic        ram_we, rd_issue, rd_load;
  logic        commit_ok, frame_drop;
  logic [32:0] mem [DEPTH];
  logic [32:0] ram_q;
  logic        unused_bits;

  assign unused_bits = ^io.wr_d_in[35:33];
  assign used        = wr_ptr_q - rd_ptr_q;

  // Writer: clr beats chk; a chk after any dropped word rewinds the whole frame.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    ovf_d        = ovf_q;
    ram_we       = 1'b0;
    commit_ok    = 1'b0;
    frame_drop   = 1'b0;
    if (io.wr_en_in) begin
      if (io.wr_clr_in) begin
        wr_ptr_d   = commit_ptr_q;
        ovf_d      = 1'b0;
        frame_drop = 1'b1;
      end else begin
        if (used < ptr_t'(DEPTH) && !ovf_q) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end else begin
          ovf_d = 1'b1;
        end
        if (io.wr_chk_in) begin
          if (!ovf_d) begin
            commit_ptr_d = wr_ptr_d;
            commit_ok    = 1'b1;
          end else begin
            wr_ptr_d   = commit_ptr_q;
            frame_drop = 1'b1;
          end
          ovf_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_issue   = 1'b0;
    rd_load    = 1'b0;
    rd_valid_d = rd_valid_q;
    unique case (state_q)
      RD_IDLE: begin
        if (rd_ptr_q != commit_ptr_q) begin
          rd_issue = 1'b1;
          rd_ptr_d = rd_ptr_q + ptr_t'(1);
          state_d  = RD_FETCH;
        end
      end
      RD_FETCH: begin
        rd_load    = 1'b1;
        rd_valid_d = 1'b1;
        state_d    = RD_HOLD;
      end
      RD_HOLD: begin
        if (rd_valid_q && io.rd_ready_in) begin
          rd_valid_d = 1'b0;
          if (rd_ptr_q != commit_ptr_q) begin
            rd_issue = 1'b1;
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
            state_d  = RD_FETCH;
          end else begin
            state_d = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Flags come from next-state pointers so they match the pointers after each edge;
  // a word in flight to the output register still counts as available.
  assign used_d  = wr_ptr_d - rd_ptr_d;
  assign full_d  = used_d >= ptr_t'(FULL_TH);
  assign avail_d = (commit_ptr_d != rd_ptr_d) || rd_valid_d || (state_d == RD_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      full_q       <= 1'b0;
      avail_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_d_q       <= '0;
      rd_last_q    <= 1'b0;
      state_q      <= RD_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
      full_q       <= full_d;
      avail_q      <= avail_d;
      rd_valid_q   <= rd_valid_d;
      state_q      <= state_d;
      if (rd_load) begin
        rd_d_q    <= ram_q[31:0];
        rd_last_q <= ram_q[32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr_q[ADDR_W-1:0]] <= io.wr_d_in[32:0];
    if (rd_issue) ram_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  assign io.wr_full_out     = full_q;
  assign io.rd_valid_out    = rd_valid_q;
  assign io.rd_d_out        = rd_d_q;
  assign io.rd_last_out     = rd_last_q;
  assign io.frame_avail_out = avail_q;

`ifdef ETH_RX_FRAME_BUF_STATS_EN
  logic [15:0] ok_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (commit_ok && ok_cnt_q != '1) ok_cnt_q <= ok_cnt_q + 16'd1;
      if (frame_drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign frames_ok_out   = ok_cnt_q;
  assign frames_drop_out = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = commit_ok ^ frame_drop;
`endif

endmodule
